// File: rtl/vga_pkg.sv
// Shared VGA timing constants and coordinate type for the timing generator and the renderer.
// Default mode is 640x480@60 Hz from a 50 MHz system clock.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE   = 640;
    localparam int unsigned DEF_H_FP       = 16;
    localparam int unsigned DEF_H_SYNC     = 96;
    localparam int unsigned DEF_H_BP       = 48;
    localparam int unsigned DEF_V_ACTIVE   = 480;
    localparam int unsigned DEF_V_FP       = 10;
    localparam int unsigned DEF_V_SYNC     = 2;
    localparam int unsigned DEF_V_BP       = 33;
    localparam int unsigned DEF_CLK_DIV    = 2;
    localparam int unsigned DEF_PIPE_DELAY = 1;

    localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    // Inclusive window test used for the sync pulse decode.
    function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Two-bit shift register that delays {hsync, vsync} by DEPTH pixel ticks so sync
// stays aligned with the renderer's colour pipeline. DEPTH=0 is a pure wire.
module sync_delay #(
    parameter int unsigned DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [1:0] i_d,
    output logic [1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = ^{clk, rst, i_en};
            assign o_q      = i_d;
        end else begin : g_shift
            logic [1:0] r_sr [DEPTH];

            // NOTE: every stage is reset (to the inactive-high sync level) so no
            // spurious sync pulse leaks out of the line for DEPTH ticks after reset.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        r_sr[i] <= 2'b11;
                    end
                end else if (i_en) begin
                    r_sr[0] <= i_d;
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        r_sr[i] <= r_sr[i-1];
                    end
                end
            end

            assign o_q = r_sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel-rate enable, DAC clock, coordinates, delayed
// active-low syncs, line/frame strobes and a free-running frame counter.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned PIPE_DELAY = DEF_PIPE_DELAY
) (
    input  logic        clk,
    input  logic        rst,
    output coord_t      pixelx,
    output coord_t      pixely,
    output logic        pix_en,
    output logic        vga_clk,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t X_LAST   = coord_t'(H_TOT - 1);
    localparam coord_t Y_LAST   = coord_t'(V_TOT - 1);
    localparam coord_t X_ACT    = coord_t'(H_ACTIVE);
    localparam coord_t Y_ACT    = coord_t'(V_ACTIVE);
    localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam int unsigned      DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] r_div;
    logic             r_vga_clk;
    coord_t           r_pixelx;
    coord_t           r_pixely;
    logic             r_line_start;
    logic             r_frame_start;
    logic [15:0]      r_frame_count;

    logic             w_pix_en;
    logic             w_x_wrap;
    logic             w_y_wrap;
    logic             w_hsync_raw;
    logic             w_vsync_raw;
    logic [1:0]       w_sync_q;

    assign w_pix_en = (r_div == DIV_LAST);
    assign w_x_wrap = w_pix_en && (r_pixelx == X_LAST);
    assign w_y_wrap = w_x_wrap && (r_pixely == Y_LAST);

    // vga_clk is taken from the current divider phase, so it lags div by one clk and
    // its rising edge lands mid-pixel rather than on the coordinate update.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div     <= '0;
            r_vga_clk <= 1'b1;
        end else begin
            r_vga_clk <= (r_div < DIV_HALF);
            r_div     <= w_pix_en ? '0 : r_div + DIV_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pixelx      <= '0;
            r_pixely      <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            if (w_pix_en) begin
                r_pixelx <= w_x_wrap ? '0 : r_pixelx + coord_t'(1);
            end
            if (w_x_wrap) begin
                r_pixely <= w_y_wrap ? '0 : r_pixely + coord_t'(1);
            end
            r_line_start  <= w_x_wrap;
            r_frame_start <= w_y_wrap;
            if (w_y_wrap) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    // NOTE: defaults first so no path through the block leaves a signal unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_hsync_raw = 1'b1;
        w_vsync_raw = 1'b1;
        if (in_window(r_pixelx, HS_START, HS_END)) begin
            w_hsync_raw = 1'b0;
        end
        if (in_window(r_pixely, VS_START, VS_END)) begin
            w_vsync_raw = 1'b0;
        end
    end

    sync_delay #(
        .DEPTH (PIPE_DELAY)
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_pix_en),
        .i_d  ({w_hsync_raw, w_vsync_raw}),
        .o_q  (w_sync_q)
    );

    assign pixelx      = r_pixelx;
    assign pixely      = r_pixely;
    assign pix_en      = w_pix_en;
    assign vga_clk     = r_vga_clk;
    assign hsync       = w_sync_q[1];
    assign vsync       = w_sync_q[0];
    assign active      = (r_pixelx < X_ACT) && (r_pixely < Y_ACT);
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: three full-size instances (PIPE_DELAY 1/0/3) for
// reset and line timing, plus a shrunken-raster instance for frame-level behaviour.
module tb_vga_timing;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rst_s;

    always #10 clk = ~clk;

    coord_t x1, y1, x0, y0, x3, y3, xs, ys;
    logic pe1, vc1, hs1, vs1, ac1, ls1, fs1;
    logic pe0, vc0, hs0, vs0, ac0, ls0, fs0;
    logic pe3, vc3, hs3, vs3, ac3, ls3, fs3;
    logic pes, vcs, hss, vss, acs, lss, fss;
    logic [15:0] fc1, fc0, fc3, fcs;

    int n_tests = 0;
    int n_fail  = 0;

    vga_timing u_d1 (
        .clk(clk), .rst(rst), .pixelx(x1), .pixely(y1), .pix_en(pe1), .vga_clk(vc1),
        .hsync(hs1), .vsync(vs1), .active(ac1), .line_start(ls1), .frame_start(fs1),
        .frame_count(fc1)
    );

    vga_timing #(.PIPE_DELAY(0)) u_d0 (
        .clk(clk), .rst(rst), .pixelx(x0), .pixely(y0), .pix_en(pe0), .vga_clk(vc0),
        .hsync(hs0), .vsync(vs0), .active(ac0), .line_start(ls0), .frame_start(fs0),
        .frame_count(fc0)
    );

    vga_timing #(.PIPE_DELAY(3)) u_d3 (
        .clk(clk), .rst(rst), .pixelx(x3), .pixely(y3), .pix_en(pe3), .vga_clk(vc3),
        .hsync(hs3), .vsync(vs3), .active(ac3), .line_start(ls3), .frame_start(fs3),
        .frame_count(fc3)
    );

    // 16x10 raster: hsync low for pixelx 10..12, vsync low for pixely 7..8.
    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_s (
        .clk(clk), .rst(rst_s), .pixelx(xs), .pixely(ys), .pix_en(pes), .vga_clk(vcs),
        .hsync(hss), .vsync(vss), .active(acs), .line_start(lss), .frame_start(fss),
        .frame_count(fcs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int f1 = -1, r1 = -1, f0 = -1, r0 = -1, f3 = -1, r3 = -1;
    logic ph1, ph0, ph3;
    int ls_c1 = -1, ls_c2 = -1, ls_y = -1, n_ls = 0, n_fs = 0;
    logic a639 = 1'bx, a640 = 1'bx;
    logic pvs;
    int vs_fall = -1, vs_rise = -1, vs_fx = -1, vs_fy = -1, fs_c = -1;

    initial begin
        rst   = 1'b0;
        rst_s = 1'b0;
        repeat (5) step();

        check("rst_pixelx", x1, 0);
        check("rst_pixely", y1, 0);
        check("rst_hsync", hs1, 1);
        check("rst_vsync", vs1, 1);
        check("rst_vga_clk", vc1, 1);
        check("rst_line_start", ls1, 0);
        check("rst_frame_start", fs1, 0);
        check("rst_frame_count", fc1, 0);
        check("rst_pix_en", pe1, 0);
        check("rst_hsync_d3", hs3, 1);

        rst = 1'b1;
        #1;
        check("pix_en_at_release", pe1, 0);
        step();
        check("pix_en_first", pe1, 1);
        check("pixelx_before_first_tick", x1, 0);
        check("vga_clk_clk1", vc1, 1);
        step();
        check("pixelx_after_first_tick", x1, 1);
        check("pix_en_clk2", pe1, 0);
        check("vga_clk_clk2", vc1, 0);

        ph1 = hs1;
        ph0 = hs0;
        ph3 = hs3;
        for (int c = 3; c <= 3300; c++) begin
            step();
            if (ph1 && !hs1 && f1 < 0) f1 = int'(x1);
            if (!ph1 && hs1 && r1 < 0) r1 = int'(x1);
            if (ph0 && !hs0 && f0 < 0) f0 = int'(x0);
            if (!ph0 && hs0 && r0 < 0) r0 = int'(x0);
            if (ph3 && !hs3 && f3 < 0) f3 = int'(x3);
            if (!ph3 && hs3 && r3 < 0) r3 = int'(x3);
            ph1 = hs1;
            ph0 = hs0;
            ph3 = hs3;
            if (ls1) begin
                n_ls++;
                if (ls_c1 < 0) begin
                    ls_c1 = c;
                    ls_y  = int'(y1);
                end else if (ls_c2 < 0) begin
                    ls_c2 = c;
                end
            end
            if (fs1) n_fs++;
            if (x1 == 10'd639) a639 = ac1;
            if (x1 == 10'd640) a640 = ac1;
        end

        check("hsync_fall_x_d1", f1, 657);
        check("hsync_rise_x_d1", r1, 753);
        check("hsync_fall_x_d0", f0, 656);
        check("hsync_rise_x_d0", r0, 752);
        check("hsync_fall_x_d3", f3, 659);
        check("hsync_rise_x_d3", r3, 755);
        check("line_start_first_clk", ls_c1, 1600);
        check("line_start_period", ls_c2 - ls_c1, 1600);
        check("line_start_pulse_count", n_ls, 2);
        check("pixely_after_wrap", ls_y, 1);
        check("no_frame_start_in_lines", n_fs, 0);
        check("active_at_639", a639, 1);
        check("active_at_640", a640, 0);

        rst_s = 1'b1;
        repeat (318) step();
        check("s_pixelx_last", xs, 15);
        check("s_pixely_last", ys, 9);
        check("s_frame_start_early", fss, 0);
        step();
        check("s_pix_en_wrap", pes, 1);
        check("s_pixelx_hold", xs, 15);
        step();
        check("s_pixelx_wrap", xs, 0);
        check("s_pixely_wrap", ys, 0);
        check("s_line_start_wrap", lss, 1);
        check("s_frame_start_wrap", fss, 1);
        check("s_frame_count_1", fcs, 1);
        step();
        check("s_line_start_one_clk", lss, 0);
        check("s_frame_start_one_clk", fss, 0);
        check("s_frame_count_hold", fcs, 1);

        pvs = vss;
        for (int c = 322; c <= 650; c++) begin
            step();
            if (pvs && !vss && vs_fall < 0) begin
                vs_fall = c;
                vs_fx   = int'(xs);
                vs_fy   = int'(ys);
            end
            if (!pvs && vss && vs_rise < 0) vs_rise = c;
            pvs = vss;
            if (fss && fs_c < 0) fs_c = c;
        end
        check("s_vsync_fall_clk", vs_fall, 546);
        check("s_vsync_fall_y", vs_fy, 7);
        check("s_vsync_fall_x", vs_fx, 1);
        check("s_vsync_low_clks", vs_rise - vs_fall, 64);
        check("s_frame_period", fs_c - 320, 320);
        check("s_frame_count_2", fcs, 2);

        repeat (886 - 650) step();
        check("s_mid_pixelx", xs, 11);
        check("s_mid_pixely", ys, 7);
        check("s_mid_hsync", hss, 0);
        check("s_mid_vsync", vss, 0);
        rst_s = 1'b0;
        #1;
        check("s_async_pixelx", xs, 0);
        check("s_async_pixely", ys, 0);
        check("s_async_hsync", hss, 1);
        check("s_async_vsync", vss, 1);
        check("s_async_frame_count", fcs, 0);
        check("s_async_vga_clk", vcs, 1);
        check("s_async_line_start", lss, 0);
        check("s_async_frame_start", fss, 0);
        step();
        rst_s = 1'b1;
        step();
        check("s_restart_pix_en", pes, 1);
        check("s_restart_pixelx0", xs, 0);
        step();
        check("s_restart_pixelx1", xs, 1);
        check("s_restart_pixely", ys, 0);
        check("s_restart_frame_count", fcs, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
# vga_timing

Generates VGA 640x480@60 Hz raster timing from the 50 MHz system clock and drives the pixel renderer directly upstream of it. Produces the pixel coordinates the renderer consumes, a pixel-rate enable, a 25 MHz DAC clock, and active-low horizontal and vertical sync. Sync is delayed to stay aligned with the renderer's colour pipeline. Also emits line-start and frame-start strobes and a frame counter for game logic and animation.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch, in lines
- CLK_DIV, 2, system clocks per pixel; must be ≥2
- PIPE_DELAY, 1, pixel ticks by which hsync/vsync lag pixelx/pixely; range 0..3
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous active-low reset
- pixelx  out  10  horizontal counter, 0..799
- pixely  out  10  vertical counter, 0..524
- pix_en  out  1  one-clk strobe; the counters advance on it
- vga_clk  out  1  DAC clock, period = CLK_DIV clks
- hsync  out  1  active-low horizontal sync, delayed by PIPE_DELAY
- vsync  out  1  active-low vertical sync, delayed by PIPE_DELAY
- active  out  1  pixelx<H_ACTIVE && pixely<V_ACTIVE, undelayed
- line_start  out  1  one-clk pulse when pixelx wraps to 0
- frame_start  out  1  one-clk pulse when pixelx and pixely both wrap to 0
- frame_count  out  16  frames completed since reset, wraps modulo 2^16

## Operation
- **Divider:** counter div runs 0..CLK_DIV-1.
  - pix_en is asserted combinationally when div==CLK_DIV-1.
  - vga_clk is registered: high while div<CLK_DIV/2, low otherwise.
  - With CLK_DIV=2 the rising edge of vga_clk falls mid-way through each pixel.
- **Horizontal counter:** on pix_en, pixelx increments. At H_TOTAL-1 (799) it wraps to 0.
- **Vertical counter:** pixely increments only when pixelx wraps. At V_TOTAL-1 (524) it wraps to 0.
- **Sync decode:**
  - hsync_raw = !(pixelx ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]), i.e. low for 656..751.
  - vsync_raw = !(pixely ∈ [490, 491]).
- **Sync delay:** a PIPE_DELAY-deep shift register, clocked only on pix_en, carries hsync_raw and vsync_raw. Its reset value is all ones. With PIPE_DELAY=0, the registered raw values pass straight through.
- **Strobes:** line_start and frame_start are registered. Each asserts for exactly one clk, in the clk after the pix_en that performed the wrap.
- **Frame counter:** frame_count increments together with frame_start.
- **Arithmetic:** all counters are unsigned. H_TOTAL and V_TOTAL are sums of the parameters, and each must be ≤1024.

## Timing
- **Reset:** asserting rst (low) asynchronously forces:
  - div=0, pixelx=0, pixely=0, frame_count=0
  - hsync=1, vsync=1, vga_clk=1
  - line_start=0, frame_start=0
- **Reset release:** the first pix_en occurs CLK_DIV clks after release. No frame_start is emitted for the reset frame.
- **Reset mid-frame:** counters and delay line clear immediately. No partial-line strobes are emitted.
- **Frame length:** H_TOTAL·V_TOTAL·CLK_DIV = 840 000 clks (16.8 ms).
- **Coordinate latency:** pixelx/pixely change in the clk after pix_en.
- **Simultaneous wraps:** when both counters wrap on the same pix_en, line_start and frame_start assert in the same cycle.
- **Sync latency:** hsync/vsync edges occur exactly PIPE_DELAY pix_en ticks after the matching coordinate values appear.

## Structure
- **Package vga_pkg:** default timing constants, H_TOTAL/V_TOTAL localparams, and a typedef `coord_t` = logic [9:0]. The renderer also imports this package.
- **Sub-module sync_delay:** parameter DEPTH and a width-2 shift register with enable and asynchronous active-low reset to ones. It is instantiated once for {hsync, vsync}.

## Test plan
- **Reset values:** hold rst low for 5 clks, then release → all outputs at reset values. First pix_en at clk 2 after release. pixelx=1 at clk 3.
- **Line period:** run 1 line → hsync falls when pixelx becomes 656+PIPE_DELAY and rises at 752+PIPE_DELAY. line_start pulses every 1600 clks. active is low for pixelx ≥640.
- **Frame period:** run 2 frames → vsync low for exactly 2 lines (3200 clks) starting at pixely=490. frame_start pulses 840 000 clks apart. frame_count=1, then 2.
- **Simultaneous wrap:** at pixelx=799, pixely=524 → next pix_en gives pixelx=0, pixely=0. line_start and frame_start are asserted together for one clk.
- **Reset mid-frame:** assert rst at pixelx=300, pixely=200 → outputs reset in the same cycle (asynchronous). After release, counting restarts from 0,0 and frame_count=0.
- **PIPE_DELAY=0 vs 3:** compare hsync edge offsets against pixelx → offsets of 0 and 3 pix_en ticks respectively.
